// File: rtl/pwm_level_ctrl.sv
// pwm_level_ctrl: front-panel level controller for the amplifier PWM stage.
//   Two raw buttons are synchronised and debounced. Up/down presses move a
//   saturating target level, and a simultaneous press toggles mute. The applied
//   duty moves toward the effective target (0 when muted) by one LSB, and only
//   on a PWM period boundary, so the PWM never sees a mid-period change.
// Ports:
//   clk       system clock
//   rst       synchronous active-high reset
//   ena       controller enable; when low, state/duty/target/mute hold
//   buttons   raw async buttons, active-high; [1]=up, [0]=down
//   pwm_step  one-cycle pulse at each PWM period boundary
//   duty      duty value applied to the PWM
//   leds      [0]=muted, [1]=ramping (FSM not idle)
module pwm_level_ctrl #(
  parameter int unsigned N              = 4,
  parameter int unsigned DEBOUNCE_TICKS = 12,
  parameter int unsigned INIT_LEVEL     = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ena,
  input  logic [1:0]   buttons,
  input  logic         pwm_step,
  output logic [N-1:0] duty,
  output logic [1:0]   leds
);

  localparam int unsigned CntW = (DEBOUNCE_TICKS > 1) ? $clog2(DEBOUNCE_TICKS) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_TICKS - 1);
  localparam logic [CntW-1:0] CntOne = CntW'(1);
  localparam logic [N-1:0] LevelMax  = {N{1'b1}};
  localparam logic [N-1:0] LevelOne  = N'(1);
  localparam logic [N-1:0] InitLevel = N'(INIT_LEVEL);

  localparam logic [1:0] StIdle     = 2'd0;
  localparam logic [1:0] StRampUp   = 2'd1;
  localparam logic [1:0] StRampDown = 2'd2;

  logic [1:0]           sync1_q, sync2_q;
  logic [1:0]           stable_q, stable_d;
  logic [1:0][CntW-1:0] cnt_q, cnt_d;
  logic [1:0]           press;
  logic [N-1:0]         target_q, target_d;
  logic                 muted_q, muted_d;
  logic [N-1:0]         duty_q, duty_d;
  logic [1:0]           state_q, state_d;
  logic [1:0]           leds_q, leds_d;
  logic [N-1:0]         eff;
  logic [N-1:0]         duty_inc, duty_dec;

  // Debounce: a change is accepted after DEBOUNCE_TICKS consecutive differing samples.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      cnt_d[i]    = cnt_q[i];
      stable_d[i] = stable_q[i];
      press[i]    = 1'b0;
      if (sync2_q[i] == stable_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CntMax) begin
        stable_d[i] = ~stable_q[i];
        cnt_d[i]    = '0;
        press[i]    = ~stable_q[i];
      end else begin
        cnt_d[i] = cnt_q[i] + CntOne;
      end
    end
  end

  // Press handling; events arriving while disabled are dropped.
  always_comb begin
    target_d = target_q;
    muted_d  = muted_q;
    if (ena) begin
      if (press[1] && press[0]) begin
        muted_d = ~muted_q;
      end else if (press[1]) begin
        if (target_q != LevelMax) target_d = target_q + LevelOne;
      end else if (press[0]) begin
        if (target_q != '0) target_d = target_q - LevelOne;
      end
    end
  end

  // Uses registered target/mute, so a step coincident with a press sees the old value.
  assign eff      = muted_q ? '0 : target_q;
  assign duty_inc = duty_q + LevelOne;
  assign duty_dec = duty_q - LevelOne;

  always_comb begin
    state_d = state_q;
    duty_d  = duty_q;
    if (ena) begin
      case (state_q)
        StIdle: begin
          if (eff > duty_q) begin
            state_d = StRampUp;
          end else if (eff < duty_q) begin
            state_d = StRampDown;
          end
        end
        StRampUp: begin
          // Target moved below us mid-ramp: drop to idle and let it re-evaluate.
          if (eff <= duty_q) begin
            state_d = StIdle;
          end else if (pwm_step) begin
            duty_d = duty_inc;
            if (duty_inc == eff) state_d = StIdle;
          end
        end
        StRampDown: begin
          if (eff >= duty_q) begin
            state_d = StIdle;
          end else if (pwm_step) begin
            duty_d = duty_dec;
            if (duty_dec == eff) state_d = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Registered from next-state so leds[1] changes on the same edge as the state.
  assign leds_d = {state_d != StIdle, muted_d};

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      stable_q <= '0;
      cnt_q    <= '0;
      target_q <= InitLevel;
      muted_q  <= 1'b0;
      duty_q   <= '0;
      state_q  <= StIdle;
      leds_q   <= 2'b00;
    end else begin
      sync1_q  <= buttons;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      target_q <= target_d;
      muted_q  <= muted_d;
      duty_q   <= duty_d;
      state_q  <= state_d;
      leds_q   <= leds_d;
    end
  end

  assign duty = duty_q;
  assign leds = leds_q;

endmodule

// File: tb/tb_pwm_level_ctrl.sv
// Directed bench for pwm_level_ctrl (N=4, DEBOUNCE_TICKS=4, INIT_LEVEL=0,
// pwm_step every 10 clocks). Outputs are sampled 1 time unit after each posedge.
module tb_pwm_level_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       ena;
  logic [1:0] buttons;
  logic       pwm_step = 1'b0;
  logic [3:0] duty;
  logic [1:0] leds;

  int errors  = 0;
  int checks  = 0;
  int illegal = 0;  // duty moves that were not a single LSB on an enabled step
  int step_cnt = 0;
  logic last_step;

  pwm_level_ctrl #(
    .N              (4),
    .DEBOUNCE_TICKS (4),
    .INIT_LEVEL     (0)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .ena      (ena),
    .buttons  (buttons),
    .pwm_step (pwm_step),
    .duty     (duty),
    .leds     (leds)
  );

  always #5 clk = ~clk;

  // Free-running period boundary, changed on the falling edge.
  always @(negedge clk) begin
    if (step_cnt == 9) step_cnt = 0;
    else step_cnt = step_cnt + 1;
    pwm_step = (step_cnt == 9);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock; also flags any illegal duty movement.
  task automatic cyc();
    logic [3:0] prev;
    logic       st, rs, en;
    prev = duty;
    @(posedge clk);
    st = pwm_step;
    rs = rst;
    en = ena;
    last_step = st;
    #1;
    if (!rs && !$isunknown(prev) && duty !== prev) begin
      if (!(st && en && (int'(duty) == int'(prev) + 1 || int'(duty) == int'(prev) - 1)))
        illegal++;
    end
  endtask

  task automatic wait_duty(input logic [3:0] exp, input int bound, input string tag);
    int n = 0;
    while (duty !== exp && n < bound) begin
      cyc();
      n++;
    end
    chk(tag, 32'(duty), 32'(exp));
  endtask

  task automatic press(input logic [1:0] b);
    buttons = b;
    repeat (20) cyc();
    buttons = 2'b00;
    repeat (20) cyc();
  endtask

  // Returns 1 time unit after an edge at which pwm_step was high.
  task automatic sync_to_step();
    int n = 0;
    do begin
      cyc();
      n++;
    end while (!last_step && n < 20);
  endtask

  initial begin
    int bad;
    rst = 1'b1;
    ena = 1'b1;
    buttons = 2'b00;
    repeat (2) cyc();
    chk("rst_duty", 32'(duty), 0);
    chk("rst_leds", 32'(leds), 0);
    chk("rst_target", 32'(dut.target_q), 0);
    rst = 1'b0;

    // Idle with no buttons for 100 cycles.
    bad = 0;
    repeat (100) begin
      cyc();
      if (duty !== 4'd0 || leds !== 2'b00) bad++;
    end
    chk("idle_hold", 32'(bad), 0);

    // Short pulses are rejected by the debouncer.
    repeat (5) begin
      buttons = 2'b10;
      repeat (2) cyc();
      buttons = 2'b00;
      repeat (6) cyc();
    end
    repeat (10) cyc();
    chk("pulse_target", 32'(dut.target_q), 0);
    chk("pulse_leds", 32'(leds), 0);

    // Long press aligned to a step: accepted at +6, ramping at +7, step at +10.
    sync_to_step();
    buttons = 2'b10;
    repeat (8) cyc();
    chk("long_target", 32'(dut.target_q), 1);
    chk("long_ramp_leds", 32'(leds), 2'b10);
    chk("long_duty_pre", 32'(duty), 0);
    repeat (2) cyc();
    chk("long_duty_step", 32'(duty), 1);
    chk("long_leds_idle", 32'(leds), 2'b00);
    repeat (10) cyc();
    buttons = 2'b00;
    repeat (20) cyc();
    chk("long_single_inc", 32'(dut.target_q), 1);

    // Ramp up to saturation.
    repeat (20) press(2'b10);
    wait_duty(4'd15, 300, "sat_duty");
    chk("sat_target", 32'(dut.target_q), 15);
    repeat (30) cyc();
    chk("sat_hold", 32'(duty), 15);
    chk("sat_leds", 32'(leds), 0);
    chk("sat_moves", 32'(illegal), 0);

    // Ramp down to the floor.
    repeat (20) press(2'b01);
    wait_duty(4'd0, 300, "floor_duty");
    chk("floor_target", 32'(dut.target_q), 0);
    repeat (30) cyc();
    chk("floor_hold", 32'(duty), 0);
    chk("floor_moves", 32'(illegal), 0);

    // Mute from duty=target=6.
    repeat (6) press(2'b10);
    wait_duty(4'd6, 200, "mute_pre_duty");
    sync_to_step();
    buttons = 2'b11;
    repeat (8) cyc();
    chk("mute_leds", 32'(leds), 2'b11);
    chk("mute_duty_pre", 32'(duty), 6);
    repeat (12) cyc();
    buttons = 2'b00;
    wait_duty(4'd0, 200, "mute_duty_zero");
    chk("mute_leds_done", 32'(leds), 2'b01);
    chk("mute_target", 32'(dut.target_q), 6);
    buttons = 2'b11;
    wait_duty(4'd6, 200, "unmute_duty");
    buttons = 2'b00;
    repeat (20) cyc();
    chk("unmute_leds", 32'(leds), 2'b00);
    chk("mute_moves", 32'(illegal), 0);

    // ena gating mid-ramp: duty=3 heading for 8.
    press(2'b11);
    wait_duty(4'd0, 200, "gate_mute_zero");
    repeat (2) press(2'b10);
    chk("gate_target_set", 32'(dut.target_q), 8);
    chk("gate_duty_muted", 32'(duty), 0);
    buttons = 2'b11;
    wait_duty(4'd3, 300, "gate_duty3");
    ena = 1'b0;
    buttons = 2'b00;
    repeat (20) cyc();
    buttons = 2'b10;
    repeat (20) cyc();
    buttons = 2'b00;
    repeat (10) cyc();
    chk("gate_duty_hold", 32'(duty), 3);
    chk("gate_target_hold", 32'(dut.target_q), 8);
    chk("gate_leds_hold", 32'(leds), 2'b10);
    ena = 1'b1;
    wait_duty(4'd8, 200, "gate_resume");
    chk("gate_resume_leds", 32'(leds), 2'b00);
    chk("gate_moves", 32'(illegal), 0);

    // Reset mid-ramp at duty=5.
    press(2'b11);
    wait_duty(4'd0, 200, "rst_mute_zero");
    buttons = 2'b11;
    wait_duty(4'd5, 300, "rst_duty5");
    chk("rst_pre_leds", 32'(leds), 2'b10);
    rst = 1'b1;
    buttons = 2'b00;
    cyc();
    rst = 1'b0;
    chk("mid_rst_duty", 32'(duty), 0);
    chk("mid_rst_leds", 32'(leds), 2'b00);
    chk("mid_rst_target", 32'(dut.target_q), 0);
    chk("mid_rst_state", 32'(dut.state_q), 0);
    repeat (40) cyc();
    chk("post_rst_duty", 32'(duty), 0);
    chk("post_rst_leds", 32'(leds), 2'b00);
    chk("post_rst_moves", 32'(illegal), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
